// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped cache controller.
package cache_pkg;

  // The stored tag field is the full address width so every LINES setting fits.
  localparam int unsigned LINE_TAG_W   = 3;
  localparam int unsigned LINE_DATA_W  = 4;
  localparam int unsigned MEM_ENTRIES  = 7;
  localparam logic [2:0]  ADDR_INVALID = 3'd7;

  typedef enum logic [2:0] {
    StIdle,
    StWriteback,
    StFillReq,
    StFillWait,
    StDone
`ifdef CACHE_FLUSH_EN
    , StFlush
`endif
  } state_t;

  typedef struct packed {
    logic                   valid;
    logic                   dirty;
    logic [LINE_TAG_W-1:0]  tag;
    logic [LINE_DATA_W-1:0] data;
  } line_t;

endpackage

// File: rtl/cache_line_array.sv
// Line storage: LINES entries, one combinational read port, one write port.
// Only valid/dirty are reset; tag/data are don't-care while a line is invalid.
module cache_line_array
  import cache_pkg::*;
#(
  parameter int unsigned LINES = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] rd_idx,
  output line_t            rd_line,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  line_t            wr_line
);

  logic [LINES-1:0]       valid_q;
  logic [LINES-1:0]       dirty_q;
  logic [LINE_TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_DATA_W-1:0] data_q [LINES];

  // State bits: cleared asynchronously, written on we.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we) begin
      valid_q[wr_idx] <= wr_line.valid;
      dirty_q[wr_idx] <= wr_line.dirty;
    end
  end

  // Payload: no reset needed.
  always_ff @(posedge clock) begin
    if (we) begin
      tag_q[wr_idx]  <= wr_line.tag;
      data_q[wr_idx] <= wr_line.data;
    end
  end

  // Combinational read by index.
  always_comb begin
    rd_line.valid = valid_q[rd_idx];
    rd_line.dirty = dirty_q[rd_idx];
    rd_line.tag   = tag_q[rd_idx];
    rd_line.data  = data_q[rd_idx];
  end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back / write-allocate cache controller.
// Optional build macro CACHE_FLUSH_EN adds flush_req/flush_done and a FLUSH walk.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned LINES   = 2,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hit,
  output logic              cpu_err,
  output logic              mem_writeback,
  output logic [2:0]        mem_tag,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_confirma
`ifdef CACHE_FLUSH_EN
  ,
  input  logic              flush_req,
  output logic              flush_done
`endif
);

  localparam int unsigned SH    = $clog2(LINES);
  localparam int unsigned IDX_W = (SH == 0) ? 1 : SH;

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
    return (LINES == 1) ? '0 : a[IDX_W-1:0];
  endfunction

  function automatic logic [LINE_TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
    return LINE_TAG_W'(a >> SH);
  endfunction

  // Rebuild the memory entry number of a cached line from its tag and index.
  function automatic logic [2:0] mem_addr_of(input logic [LINE_TAG_W-1:0] t,
                                             input logic [IDX_W-1:0] i);
    logic [LINE_TAG_W-1:0] ie;
    ie = LINE_TAG_W'(i);
    return (t << SH) | ie;
  endfunction

  state_t            state_q;
  logic              req_we_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic [7:0]        cnt_q;
`ifdef CACHE_FLUSH_EN
  logic [2:0]        fidx_q;
`endif

  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [IDX_W-1:0]  rd_idx;
  line_t             rd_line;
  line_t             wr_line;
  logic              line_we;
  logic              hit;
  logic              victim_dirty;
  logic              accept;

  cache_line_array #(
    .LINES(LINES),
    .IDX_W(IDX_W)
  ) u_lines (
    .clock  (clock),
    .reset_n(reset_n),
    .rd_idx (rd_idx),
    .rd_line(rd_line),
    .we     (line_we),
    .wr_idx (rd_idx),
    .wr_line(wr_line)
  );

  assign cpu_ready = (state_q == StIdle);
`ifdef CACHE_FLUSH_EN
  assign accept = (state_q == StIdle) && cpu_req && !flush_req;
`else
  assign accept = (state_q == StIdle) && cpu_req;
`endif

  // Line lookup: live request in IDLE, captured request otherwise.
  always_comb begin
    cur_addr  = (state_q == StIdle) ? cpu_addr : req_addr_q;
    cur_wdata = (state_q == StIdle) ? cpu_wdata : req_wdata_q;
    rd_idx    = idx_of(cur_addr);
`ifdef CACHE_FLUSH_EN
    if (state_q == StFlush) rd_idx = fidx_q[IDX_W-1:0];
`endif
    hit          = rd_line.valid && (rd_line.tag == tag_of(cur_addr));
    victim_dirty = rd_line.valid && rd_line.dirty;
  end

  // Line array updates: installs, write hits, victim invalidation, flush cleaning.
  always_comb begin
    line_we       = 1'b0;
    wr_line.valid = 1'b1;
    wr_line.dirty = 1'b1;
    wr_line.tag   = tag_of(cur_addr);
    wr_line.data  = cur_wdata;
    unique case (state_q)
      StIdle: begin
        line_we = accept && (cpu_addr != ADDR_INVALID) && cpu_we && (hit || !victim_dirty);
      end
      StWriteback: begin
        line_we = 1'b1;
        if (!req_we_q) begin
          wr_line.valid = 1'b0;
          wr_line.dirty = 1'b0;
        end
      end
      StFillWait: begin
        line_we       = mem_confirma;
        wr_line.dirty = 1'b0;
        wr_line.data  = mem_rdata;
      end
`ifdef CACHE_FLUSH_EN
      StFlush: begin
        line_we       = (fidx_q < 3'(LINES)) && victim_dirty;
        wr_line.dirty = 1'b0;
        wr_line.tag   = rd_line.tag;
        wr_line.data  = rd_line.data;
      end
`endif
      default: ;
    endcase
  end

  // Controller FSM with registered CPU and memory outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      req_we_q      <= 1'b0;
      req_addr_q    <= '0;
      req_wdata_q   <= '0;
      cnt_q         <= '0;
      cpu_ack       <= 1'b0;
      cpu_hit       <= 1'b0;
      cpu_err       <= 1'b0;
      cpu_rdata     <= '0;
      mem_writeback <= 1'b0;
      mem_tag       <= '0;
      mem_wdata     <= '0;
`ifdef CACHE_FLUSH_EN
      fidx_q        <= '0;
      flush_done    <= 1'b0;
`endif
    end else begin
      cpu_ack       <= 1'b0;
      mem_writeback <= 1'b0;
`ifdef CACHE_FLUSH_EN
      flush_done    <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
`ifdef CACHE_FLUSH_EN
          if (flush_req) begin
            state_q <= StFlush;
            fidx_q  <= '0;
          end
`endif
          if (accept) begin
            req_we_q    <= cpu_we;
            req_addr_q  <= cpu_addr;
            req_wdata_q <= cpu_wdata;
            cpu_hit     <= 1'b0;
            cpu_err     <= 1'b0;
            cpu_rdata   <= '0;
            if (cpu_addr == ADDR_INVALID) begin
              state_q <= StDone;
              cpu_ack <= 1'b1;
              cpu_err <= 1'b1;
            end else if (hit) begin
              state_q <= StDone;
              cpu_ack <= 1'b1;
              cpu_hit <= 1'b1;
              if (!cpu_we) cpu_rdata <= rd_line.data;
            end else if (victim_dirty) begin
              state_q       <= StWriteback;
              mem_writeback <= 1'b1;
              mem_tag       <= mem_addr_of(rd_line.tag, rd_idx);
              mem_wdata     <= rd_line.data;
            end else if (cpu_we) begin
              state_q <= StDone;
              cpu_ack <= 1'b1;
            end else begin
              state_q <= StFillReq;
              mem_tag <= cpu_addr;
            end
          end
        end
        StWriteback: begin
          if (req_we_q) begin
            state_q <= StDone;
            cpu_ack <= 1'b1;
          end else begin
            state_q <= StFillReq;
            mem_tag <= req_addr_q;
          end
        end
        StFillReq: begin
          state_q <= StFillWait;
          cnt_q   <= '0;
        end
        StFillWait: begin
          if (mem_confirma) begin
            state_q   <= StDone;
            cpu_ack   <= 1'b1;
            cpu_rdata <= mem_rdata;
          end else begin
            cnt_q <= cnt_q + 8'd1;
            // Give up once TIMEOUT unconfirmed FILL_WAIT cycles have elapsed.
            if (cnt_q + 8'd1 == 8'(TIMEOUT)) begin
              state_q   <= StDone;
              cpu_ack   <= 1'b1;
              cpu_err   <= 1'b1;
              cpu_rdata <= '0;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
`ifdef CACHE_FLUSH_EN
        // One line per cycle; the extra final cycle lets the last writeback be seen.
        StFlush: begin
          if (fidx_q == 3'(LINES)) begin
            state_q    <= StIdle;
            flush_done <= 1'b1;
          end else begin
            if (victim_dirty) begin
              mem_writeback <= 1'b1;
              mem_tag       <= mem_addr_of(rd_line.tag, rd_idx);
              mem_wdata     <= rd_line.data;
            end
            fidx_q <= fidx_q + 3'd1;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: an address-level cache/memory model predicts
// each response and writeback; independent monitors compare what the DUT shows.
module tb_cache_ctrl;

  localparam int LINES   = 2;
  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 4;
  localparam int TIMEOUT = 8;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_ready, cpu_ack, cpu_hit, cpu_err;
  logic [DATA_W-1:0] cpu_rdata;
  logic              mem_writeback;
  logic [2:0]        mem_tag;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_confirma = 1'b0;
`ifdef CACHE_FLUSH_EN
  logic              flush_req = 1'b0;
  logic              flush_done;
`endif

  cache_ctrl #(
    .LINES  (LINES),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_ready    (cpu_ready),
    .cpu_ack      (cpu_ack),
    .cpu_rdata    (cpu_rdata),
    .cpu_hit      (cpu_hit),
    .cpu_err      (cpu_err),
    .mem_writeback(mem_writeback),
    .mem_tag      (mem_tag),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_confirma (mem_confirma)
`ifdef CACHE_FLUSH_EN
    ,
    .flush_req    (flush_req),
    .flush_done   (flush_done)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Backing memory seen by the DUT.
  logic [3:0] mem [8] = '{4'hA, 4'h3, 4'hA, 4'h2, 4'h7, 4'hC, 4'hE, 4'h0};
  always @(posedge clock) if (mem_writeback) mem[mem_tag] <= mem_wdata;
  assign mem_rdata = mem[mem_tag];

  // Reference model: per-line cached address, and expected memory contents.
  logic [3:0] ref_mem [8] = '{4'hA, 4'h3, 4'hA, 4'h2, 4'h7, 4'hC, 4'hE, 4'h0};
  bit         m_valid [LINES];
  bit         m_dirty [LINES];
  int         m_addr  [LINES];
  logic [3:0] m_data  [LINES];
  logic [2:0] exp_mem_tag = 3'd0;

  typedef struct {
    int         cyc;
    logic [3:0] rdata;
    bit         chk_rd;
    bit         hit;
    bit         err;
    logic [2:0] mtag;
  } exp_t;
  typedef struct {
    logic [2:0] tag;
    logic [3:0] data;
  } wb_t;

  exp_t sb[$];
  wb_t  wbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    exp_mem_tag = 3'd0;
    sb.delete();
    wbq.delete();
  endfunction

  function automatic void evict(input int idx);
    wb_t w;
    w.tag  = 3'(m_addr[idx]);
    w.data = m_data[idx];
    wbq.push_back(w);
    ref_mem[m_addr[idx]] = m_data[idx];
    exp_mem_tag = 3'(m_addr[idx]);
  endfunction

  // Predicts response, latency (accept edge to ack) and fill timing for one request.
  function automatic void model_req(input bit we, input int addr, input logic [3:0] wdata,
                                    input int d, output int lat, output int fw_off,
                                    output int cf_off, output exp_t e);
    int idx;
    bit wb;
    idx      = addr % LINES;
    e.chk_rd = !we;
    e.hit    = 0;
    e.err    = 0;
    e.rdata  = 4'h0;
    fw_off   = 1000;
    cf_off   = -1;
    if (addr == 7) begin
      e.err = 1;
      lat   = 1;
    end else if (m_valid[idx] && m_addr[idx] == addr) begin
      e.hit = 1;
      lat   = 1;
      if (we) begin
        m_data[idx]  = wdata;
        m_dirty[idx] = 1;
      end else begin
        e.rdata = m_data[idx];
      end
    end else begin
      wb = m_valid[idx] && m_dirty[idx];
      if (wb) begin
        evict(idx);
        m_valid[idx] = 0;
      end
      if (we) begin
        m_valid[idx] = 1;
        m_dirty[idx] = 1;
        m_addr[idx]  = addr;
        m_data[idx]  = wdata;
        lat          = wb ? 2 : 1;
      end else begin
        exp_mem_tag = 3'(addr);
        fw_off      = wb ? 3 : 2;
        if (d < TIMEOUT) begin
          e.rdata      = ref_mem[addr];
          m_valid[idx] = 1;
          m_dirty[idx] = 0;
          m_addr[idx]  = addr;
          m_data[idx]  = ref_mem[addr];
          lat          = fw_off + 1 + d;
          cf_off       = fw_off + d;
        end else begin
          e.err = 1;
          lat   = fw_off + TIMEOUT;
        end
      end
    end
    e.mtag = exp_mem_tag;
  endfunction

  // Issue one request; d = unconfirmed FILL_WAIT cycles before confirma (>=TIMEOUT: none).
  task automatic issue(input bit we, input int addr, input logic [3:0] wdata, input int d);
    exp_t e;
    int   lat, fw_off, cf_off, c0;
    @(negedge clock);
    chk("ready before request", int'(cpu_ready), 1);
    cpu_req      = 1'b1;
    cpu_we       = we;
    cpu_addr     = 3'(addr);
    cpu_wdata    = wdata;
    mem_confirma = 1'($urandom_range(0, 1));
    model_req(we, addr, wdata, d, lat, fw_off, cf_off, e);
    c0    = cyc + 1;
    e.cyc = c0 + lat - 1;
    sb.push_back(e);
    // Busy cycles: noisy CPU inputs must be ignored; confirma noise only outside FILL_WAIT.
    for (int k = 1; k <= lat; k++) begin
      @(negedge clock);
      cpu_req   = 1'($urandom_range(0, 1));
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 3'($urandom_range(0, 7));
      cpu_wdata = 4'($urandom_range(0, 15));
      if (k >= fw_off) mem_confirma = (k == cf_off);
      else mem_confirma = 1'($urandom_range(0, 1));
    end
    @(negedge clock);
    cpu_req = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clock);
  endtask

  // Monitor: compares every ack and every writeback pulse against the queues.
  always @(negedge clock) begin : mon
    exp_t e;
    wb_t  w;
    if (reset_n) begin
      if (cpu_ack) begin
        if (sb.size() == 0) begin
          chk("unexpected ack", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("ack cycle", cyc, e.cyc);
          chk("hit", int'(cpu_hit), int'(e.hit));
          chk("err", int'(cpu_err), int'(e.err));
          if (e.chk_rd) chk("rdata", int'(cpu_rdata), int'(e.rdata));
          chk("mem_tag at ack", int'(mem_tag), int'(e.mtag));
        end
      end
      if (sb.size() > 0 && cyc > sb[0].cyc) begin
        e = sb.pop_front();
        chk("ack missing by cycle", cyc, e.cyc);
      end
      if (mem_writeback) begin
        if (wbq.size() == 0) begin
          chk("unexpected mem_writeback", 1, 0);
        end else begin
          w = wbq.pop_front();
          chk("writeback tag", int'(mem_tag), int'(w.tag));
          chk("writeback data", int'(mem_wdata), int'(w.data));
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("reset ready", int'(cpu_ready), 1);
    chk("reset ack", int'(cpu_ack), 0);
    chk("reset hit", int'(cpu_hit), 0);
    chk("reset err", int'(cpu_err), 0);
    chk("reset rdata", int'(cpu_rdata), 0);
    chk("reset mem_writeback", int'(mem_writeback), 0);
    chk("reset mem_tag", int'(mem_tag), 0);
    chk("reset mem_wdata", int'(mem_wdata), 0);

    // Cold miss then hit on address 0.
    issue(0, 0, 4'h0, 0);
    issue(0, 0, 4'h0, 0);
    // Write hit, conflicting read with dirty victim, read back the written-back data.
    issue(1, 0, 4'h5, 0);
    issue(0, 2, 4'h0, 0);
    issue(0, 0, 4'h0, 0);
    // Out-of-range address.
    issue(0, 7, 4'h0, 0);
    // Fill timeout, then a slow but confirmed fill.
    issue(0, 3, 4'h0, TIMEOUT);
    issue(0, 3, 4'h0, 1);

    // Reset during FILL_WAIT of a read of 5.
    @(negedge clock);
    cpu_req      = 1'b1;
    cpu_we       = 1'b0;
    cpu_addr     = 3'd5;
    mem_confirma = 1'b0;
    @(negedge clock);
    cpu_req = 1'b0;
    @(negedge clock);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid-fill reset ready", int'(cpu_ready), 1);
    chk("mid-fill reset ack", int'(cpu_ack), 0);
    chk("mid-fill reset err", int'(cpu_err), 0);
    chk("mid-fill reset rdata", int'(cpu_rdata), 0);
    chk("mid-fill reset mem_writeback", int'(mem_writeback), 0);
    chk("mid-fill reset mem_tag", int'(mem_tag), 0);
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    issue(0, 5, 4'h0, 0);

    // Randomised traffic.
    for (int n = 0; n < 80; n++) begin
      int d;
      d = ($urandom_range(0, 7) == 0) ? TIMEOUT + int'($urandom_range(0, 2))
                                      : int'($urandom_range(0, 3));
      issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            4'($urandom_range(0, 15)), d);
    end

`ifdef CACHE_FLUSH_EN
    begin
      bit got;
      issue(1, 3, 4'h9, 0);
      @(negedge clock);
      flush_req = 1'b1;
      for (int i = 0; i < LINES; i++) begin
        if (m_valid[i] && m_dirty[i]) begin
          evict(i);
          m_dirty[i] = 0;
        end
      end
      @(negedge clock);
      flush_req = 1'b0;
      got = 0;
      for (int k = 0; k < LINES + 6 && !got; k++) begin
        if (flush_done) got = 1;
        else @(negedge clock);
      end
      chk("flush_done seen", int'(got), 1);
      @(negedge clock);
      issue(0, 3, 4'h0, 0);
    end
`endif

    repeat (6) @(negedge clock);
    chk("all acks received", sb.size(), 0);
    chk("all writebacks seen", wbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the stimulus itself stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
